// File: rtl/mux_scan_if.sv
// Channel data in, key/mode controls in, selected data and channel indicators out.
interface mux_scan_if #(
  parameter int CH_NUM = 4,
  parameter int DATA_W = 1,
  parameter int SEL_W  = 2
);
  logic [CH_NUM*DATA_W-1:0] din;
  logic                     key_n;
  logic                     mode;
  logic [DATA_W-1:0]        dout;
  logic [SEL_W-1:0]         sel;
  logic [CH_NUM-1:0]        sel_onehot;

  modport master (output din, key_n, mode, input dout, sel, sel_onehot);
  modport slave  (input din, key_n, mode, output dout, sel, sel_onehot);
endinterface

// File: rtl/mux_scan.sv
// N-channel registered mux whose channel is stepped by a debounced key
// or advanced by a periodic auto-scan.
module mux_scan #(
  parameter int CH_NUM   = 4,
  parameter int DATA_W   = 1,
  parameter int SEL_W    = 2,
  parameter int DEB_CYC  = 240000,
  parameter int SCAN_CYC = 12000000
) (
  input  logic       clk,
  input  logic       rst_n,
  mux_scan_if.slave  bus
);

  localparam int DEB_W  = (DEB_CYC  > 2) ? $clog2(DEB_CYC)  : 1;
  localparam int SCAN_W = (SCAN_CYC > 2) ? $clog2(SCAN_CYC) : 1;
  localparam logic [DEB_W-1:0]  DEB_TC  = DEB_W'(DEB_CYC - 1);
  localparam logic [SCAN_W-1:0] SCAN_TC = SCAN_W'(SCAN_CYC - 1);
  localparam logic [SEL_W-1:0]  SEL_MAX = SEL_W'(CH_NUM - 1);

  logic              key_sync1, key_sync2;
  logic              mode_sync1, mode_sync2, mode_d;
  logic              vld1, vld2, armed;
  logic              key_stable, key_stable_d, key_stable_nxt;
  logic [DEB_W-1:0]  deb_cnt, deb_nxt;
  logic [SCAN_W-1:0] scan_cnt, scan_nxt;
  logic [SEL_W-1:0]  sel_q, sel_nxt;
  logic [CH_NUM-1:0] onehot_q, onehot_nxt;
  logic [DATA_W-1:0] dout_q, dout_nxt;
  logic              step, mode_chg, scan_wrap, adv;

  // Press only counts once a genuine released sample has been seen since
  // reset, so a key held through reset cannot step the channel.
  assign step      = armed & key_stable_d & ~key_stable;
  assign mode_chg  = mode_sync2 ^ mode_d;
  assign scan_wrap = mode_sync2 & ~mode_chg & (scan_cnt == SCAN_TC);
  assign adv       = step | scan_wrap;

  always_comb begin
    key_stable_nxt = key_stable;
    deb_nxt        = '0;
    if (key_sync2 != key_stable) begin
      if (deb_cnt == DEB_TC) begin
        key_stable_nxt = key_sync2;
      end else begin
        deb_nxt = deb_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    scan_nxt = '0;
    if (mode_sync2 && !mode_chg && !adv) begin
      scan_nxt = scan_cnt + 1'b1;
    end
  end

  always_comb begin
    sel_nxt    = sel_q;
    onehot_nxt = '0;
    dout_nxt   = '0;
    if (adv) begin
      sel_nxt = (sel_q == SEL_MAX) ? '0 : sel_q + 1'b1;
    end
    for (int k = 0; k < CH_NUM; k++) begin
      if (sel_nxt == SEL_W'(k)) begin
        onehot_nxt[k] = 1'b1;
        dout_nxt      = bus.din[k*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_sync1    <= 1'b1;
      key_sync2    <= 1'b1;
      mode_sync1   <= 1'b0;
      mode_sync2   <= 1'b0;
      mode_d       <= 1'b0;
      vld1         <= 1'b0;
      vld2         <= 1'b0;
      armed        <= 1'b0;
      key_stable   <= 1'b1;
      key_stable_d <= 1'b1;
      deb_cnt      <= '0;
      scan_cnt     <= '0;
      sel_q        <= '0;
      onehot_q     <= CH_NUM'(1);
      dout_q       <= '0;
    end else begin
      key_sync1    <= bus.key_n;
      key_sync2    <= key_sync1;
      mode_sync1   <= bus.mode;
      mode_sync2   <= mode_sync1;
      mode_d       <= mode_sync2;
      vld1         <= 1'b1;
      vld2         <= vld1;
      if (vld2 && key_sync2) begin
        armed <= 1'b1;
      end
      key_stable   <= key_stable_nxt;
      key_stable_d <= key_stable;
      deb_cnt      <= deb_nxt;
      scan_cnt     <= scan_nxt;
      sel_q        <= sel_nxt;
      onehot_q     <= onehot_nxt;
      dout_q       <= dout_nxt;
    end
  end

  assign bus.dout       = dout_q;
  assign bus.sel        = sel_q;
  assign bus.sel_onehot = onehot_q;

endmodule

// File: tb/tb_mux_scan.sv
// Directed vector bench for mux_scan with CH_NUM=3, DATA_W=2, DEB_CYC=4, SCAN_CYC=8.
module tb_mux_scan;

  localparam logic [5:0] D  = 6'b11_10_01;
  localparam logic [5:0] D0 = 6'b11_10_00;

  typedef struct {
    logic [5:0] din;
    logic       key_n;
    logic       mode;
    int         cyc;
    logic [1:0] sel;
    logic [2:0] oh;
    logic [1:0] dout;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  int   n_chk = 0;
  int   n_err = 0;
  vec_t vecs[$];

  mux_scan_if #(.CH_NUM(3), .DATA_W(2), .SEL_W(2)) bus ();

  mux_scan #(
    .CH_NUM(3), .DATA_W(2), .SEL_W(2), .DEB_CYC(4), .SCAN_CYC(8)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic void add(input logic [5:0] d, input logic k, input logic m,
                              input int c, input logic [1:0] s, input logic [2:0] o,
                              input logic [1:0] q);
    vec_t v;
    v.din = d; v.key_n = k; v.mode = m; v.cyc = c;
    v.sel = s; v.oh = o; v.dout = q;
    vecs.push_back(v);
  endfunction

  task automatic chk(input string nm, input int idx, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s[%0d]: got %0h expected %0h", nm, idx, got, exp);
    end
  endtask

  task automatic chk_out(input int idx, input logic [1:0] s, input logic [2:0] o,
                         input logic [1:0] q);
    chk("sel", idx, 32'(bus.sel), 32'(s));
    chk("sel_onehot", idx, 32'(bus.sel_onehot), 32'(o));
    chk("dout", idx, 32'(bus.dout), 32'(q));
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    // reset release, din latency
    add(D,  1, 0, 1, 0, 3'b001, 2'b01);
    add(D0, 1, 0, 1, 0, 3'b001, 2'b00);
    add(D,  1, 0, 1, 0, 3'b001, 2'b01);
    // clean presses: step lands exactly on edge 7, wrap 2 -> 0
    add(D, 0, 0, 6, 0, 3'b001, 2'b01);
    add(D, 0, 0, 1, 1, 3'b010, 2'b10);
    add(D, 0, 0, 3, 1, 3'b010, 2'b10);
    add(D, 1, 0, 8, 1, 3'b010, 2'b10);
    add(D, 0, 0, 7, 2, 3'b100, 2'b11);
    add(D, 0, 0, 3, 2, 3'b100, 2'b11);
    add(D, 1, 0, 8, 2, 3'b100, 2'b11);
    add(D, 0, 0, 7, 0, 3'b001, 2'b01);
    add(D, 0, 0, 3, 0, 3'b001, 2'b01);
    add(D, 1, 0, 8, 0, 3'b001, 2'b01);
    // bouncing press: one step only
    add(D, 0, 0, 1, 0, 3'b001, 2'b01);
    add(D, 1, 0, 1, 0, 3'b001, 2'b01);
    add(D, 0, 0, 2, 0, 3'b001, 2'b01);
    add(D, 1, 0, 1, 0, 3'b001, 2'b01);
    add(D, 0, 0, 3, 0, 3'b001, 2'b01);
    add(D, 1, 0, 1, 0, 3'b001, 2'b01);
    add(D, 0, 0, 6, 0, 3'b001, 2'b01);
    add(D, 0, 0, 1, 1, 3'b010, 2'b10);
    add(D, 0, 0, 3, 1, 3'b010, 2'b10);
    add(D, 1, 0, 8, 1, 3'b010, 2'b10);
    // 3-cycle glitches alone
    add(D, 0, 0, 3, 1, 3'b010, 2'b10);
    add(D, 1, 0, 1, 1, 3'b010, 2'b10);
    add(D, 0, 0, 3, 1, 3'b010, 2'b10);
    add(D, 1, 0, 8, 1, 3'b010, 2'b10);
    // auto scan, 8-cycle dwell
    add(D, 1, 1, 10, 1, 3'b010, 2'b10);
    add(D, 1, 1, 1,  2, 3'b100, 2'b11);
    add(D, 1, 1, 7,  2, 3'b100, 2'b11);
    add(D, 1, 1, 1,  0, 3'b001, 2'b01);
    add(D, 1, 1, 8,  1, 3'b010, 2'b10);
    add(D, 1, 1, 8,  2, 3'b100, 2'b11);
    // step pulse coinciding with scan wrap
    add(D, 1, 1, 1, 2, 3'b100, 2'b11);
    add(D, 0, 1, 7, 0, 3'b001, 2'b01);
    add(D, 0, 1, 3, 0, 3'b001, 2'b01);
    add(D, 1, 1, 4, 0, 3'b001, 2'b01);
    add(D, 1, 1, 1, 1, 3'b010, 2'b10);
    // mode toggle mid-dwell
    add(D, 1, 1, 3,  1, 3'b010, 2'b10);
    add(D, 1, 0, 5,  1, 3'b010, 2'b10);
    add(D, 1, 1, 10, 1, 3'b010, 2'b10);
    add(D, 1, 1, 1,  2, 3'b100, 2'b11);

    rst_n       = 1'b0;
    bus.din     = D;
    bus.key_n   = 1'b1;
    bus.mode    = 1'b0;
    cyc(3);
    chk_out(-1, 0, 3'b001, 2'b00);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      bus.din   = vecs[i].din;
      bus.key_n = vecs[i].key_n;
      bus.mode  = vecs[i].mode;
      cyc(vecs[i].cyc);
      chk_out(i, vecs[i].sel, vecs[i].oh, vecs[i].dout);
    end

    // reset during a press in progress, key held through and after reset
    bus.key_n = 1'b0;
    cyc(4);
    chk_out(100, 2, 3'b100, 2'b11);
    rst_n    = 1'b0;
    bus.mode = 1'b0;
    #1;
    chk_out(101, 0, 3'b001, 2'b00);
    cyc(1);
    rst_n = 1'b1;
    cyc(20);
    chk_out(102, 0, 3'b001, 2'b01);
    bus.key_n = 1'b1;
    cyc(8);
    chk_out(103, 0, 3'b001, 2'b01);
    bus.key_n = 1'b0;
    cyc(6);
    chk_out(104, 0, 3'b001, 2'b01);
    cyc(1);
    chk_out(105, 1, 3'b010, 2'b10);
    bus.key_n = 1'b1;
    cyc(8);
    chk_out(106, 1, 3'b010, 2'b10);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/mux_scan.md
# mux_scan

Parametrised N-channel, W-bit multiplexer with registered output and sequential channel selection, for the STEP FPGA lab designs. It is the next generation of the 2:1 LED mux lab. Channel select is no longer a raw switch input. It comes either from a debounced push-button that steps the channel, or from an automatic scan that cycles through the channels at a fixed period. The output drives board LEDs directly, and a one-hot channel indicator is provided for display.

## Interface
- CH_NUM, 4 — number of input channels, 2..16; need not be a power of two
- DATA_W, 1 — bits per channel
- SEL_W, 2 — select width; must satisfy 2**SEL_W >= CH_NUM
- DEB_CYC, 240000 — debounce stability window in clk cycles (20 ms at 12 MHz); minimum 2
- SCAN_CYC, 12000000 — auto-scan dwell per channel in clk cycles (1 s at 12 MHz); minimum 2

Ports:
- clk  in  1  system clock; all state changes on its rising edge
- rst_n  in  1  asynchronous, active-low reset
- din  in  CH_NUM*DATA_W  channel data; channel k occupies din[k*DATA_W +: DATA_W]; treated as synchronous to clk
- key_n  in  1  asynchronous push-button, active-low (pressed = 0)
- mode  in  1  asynchronous switch: 0 = manual step, 1 = auto scan
- dout  out  DATA_W  registered data of the selected channel
- sel  out  SEL_W  current channel index, registered
- sel_onehot  out  CH_NUM  one-hot copy of sel, registered

## Operation
- Reset (rst_n = 0, asynchronous):
  - sel = 0, sel_onehot = 1 (bit 0 set), dout = 0.
  - Debounce and scan counters = 0.
  - The debounced key state is set to released (1).
  - Synchroniser flops are set to key_n = 1 and mode = 0.
- Synchronisation: key_n and mode each pass through a 2-flop synchroniser. Only the synchronised versions are used.
- Debounce:
  - A counter runs while the synchronised key differs from the stable key state.
  - When the counter reaches DEB_CYC-1 with the difference still present, the stable state takes the new value and the counter clears.
  - Any cycle where the synchronised key equals the stable state clears the counter. A glitch shorter than DEB_CYC therefore has no effect.
- Step pulse: a 1-cycle pulse fires on the stable state's 1→0 transition (press only). A release produces nothing.
- Manual mode (mode = 0):
  - Each step pulse advances sel by one.
  - The scan counter is held at 0.
- Auto mode (mode = 1):
  - The scan counter counts 0..SCAN_CYC-1. On reaching SCAN_CYC-1 it wraps to 0 and sel advances.
  - A step pulse in auto mode also advances sel and clears the scan counter.
  - If a step pulse and the scan wrap occur in the same cycle, sel advances by exactly one and the counter restarts at 0.
- Wrap: sel advances as sel = CH_NUM-1 → 0, otherwise sel+1. Indices ≥ CH_NUM never appear.
- Mode change: any change of synchronised mode clears the scan counter in that cycle. sel is retained across the change.
- sel_onehot is updated in the same cycle as sel and always equals 1 << sel.
- Data path: every cycle, dout <= din[sel_next*DATA_W +: DATA_W], where sel_next is the value sel takes at the same edge. dout therefore always corresponds to the current sel, and din changes appear at dout one cycle later.

## Timing
- din → dout latency: 1 clk.
- key_n press → sel change: exactly DEB_CYC+3 rising edges, counted from the first edge that samples key_n = 0. key_n must stay low throughout that window.
- Release to re-arm: a release must be stable for DEB_CYC cycles before the next press is recognised.
- Auto dwell: sel holds each value for exactly SCAN_CYC cycles when no key press occurs.
- mode change → scan behaviour: takes effect 2 cycles after the change at the pin (synchroniser delay).
- Reset mid-operation: all outputs return to their reset values immediately. A press in progress is discarded. After rst_n deasserts, the key must be released and then pressed again to step.

## Test plan
Parameters for all scenarios: CH_NUM=3, DATA_W=2, DEB_CYC=4, SCAN_CYC=8.
1. Reset, then din = {2'b11, 2'b10, 2'b01} → sel = 0, sel_onehot = 3'b001, and dout = 2'b01 one cycle after reset release. Change din[1:0] to 2'b00 → dout = 2'b00 one cycle later.
2. Manual mode, clean press held 10 cycles → sel = 1 at exactly edge 7 (DEB_CYC+3); dout = 2'b10 at the same edge. A second and a third press → sel = 2, then sel = 0 (wrap). sel_onehot tracks each step.
3. Manual mode, key_n bouncing with low pulses of 1–3 cycles separated by 1 high cycle, then low for 10 cycles → exactly one step. The 3-cycle glitches alone → no step.
4. Auto mode, key idle → sel sequence 0, 1, 2, 0, … changing every 8 cycles; dout follows with the matching channel data.
5. Auto mode, press arranged so the step pulse coincides with the scan wrap → sel advances by one only, and the next auto step comes 8 cycles later. Toggle mode mid-dwell → sel retained, and the scan counter restarts from 0.
6. Assert rst_n low for 1 cycle while sel = 2 and a press is mid-debounce → outputs immediately return to sel = 0, sel_onehot = 001, dout = 0. Holding the key after reset produces no step.
